// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - keypad code lock with lockout and two-entry code change (optional LOCKOUT_TIMER_EN)
module keypad_lock_ctrl #(
    parameter int                  DIGITS         = 4,
    parameter int                  MAX_WRONG      = 3,
    parameter int                  OPEN_CYCLES    = 100,
    parameter int                  LOCKOUT_CYCLES = 1000,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h2432
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [11:0]           i_key,
    output logic                  o_open,
    output logic                  o_save_light,
    output logic                  o_locked,
    output logic                  o_change_mode,
    output logic [4*DIGITS-1:0]   o_data,
    output logic [3:0]            o_wrong_cnt
);
    localparam int CW   = 4 * DIGITS;
    localparam int NW   = $clog2(DIGITS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_CHG_NEW, S_CHG_CONFIRM, S_SAVED, S_LOCKOUT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [11:0]     r_key_q;
    logic [11:0]     r_key_q2;
    logic [CW-1:0]   r_code;
    logic [CW-1:0]   r_pending;
    logic [NW-1:0]   r_cnt;
    logic [TW-1:0]   r_timer;
    logic [3:0]      w_wrong_next;
    logic [3:0]      w_digit_val;
    logic            w_event;
    logic            w_enter;
    logic            w_star;
    logic            w_digit_ev;
    logic            w_full;
    logic            w_match;
    logic            w_accepting;
    logic            w_open_d;
    logic            w_save_d;
    logic            w_locked_d;
    logic            w_change_d;

    // Key press detection: a clean one-hot sample preceded by an idle sample
    always_comb begin
        w_event     = (r_key_q != 12'd0) && ((r_key_q & (r_key_q - 12'd1)) == 12'd0)
                      && (r_key_q2 == 12'd0);
        w_enter     = w_event && r_key_q[9];
        w_star      = w_event && r_key_q[11];
        w_digit_ev  = w_event && !r_key_q[9] && !r_key_q[11];
        w_digit_val = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r_key_q[i]) w_digit_val = 4'(i + 1);
        end
        w_full      = (r_cnt == NW'(DIGITS));
        w_match     = w_full && (o_data == r_code);
        w_accepting = (r_state == S_IDLE) || (r_state == S_CHG_NEW) || (r_state == S_CHG_CONFIRM);
    end

    // Next-state and wrong-attempt bookkeeping
    always_comb begin
        w_state_next = r_state;
        w_wrong_next = o_wrong_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_enter || w_star) begin
                    if (w_match) begin
                        w_state_next = w_enter ? S_OPEN : S_CHG_NEW;
                        w_wrong_next = 4'd0;
                    end else begin
                        w_wrong_next = o_wrong_cnt + 4'd1;
                        if (w_wrong_next == 4'(MAX_WRONG)) w_state_next = S_LOCKOUT;
                    end
                end
            end
            S_OPEN, S_SAVED: begin
                if (r_timer == '0) w_state_next = S_IDLE;
            end
            S_CHG_NEW: begin
                if (w_star)                 w_state_next = S_IDLE;
                else if (w_enter && w_full) w_state_next = S_CHG_CONFIRM;
            end
            S_CHG_CONFIRM: begin
                if (w_star) w_state_next = S_IDLE;
                else if (w_enter)
                    w_state_next = (w_full && o_data == r_pending) ? S_SAVED : S_IDLE;
            end
            S_LOCKOUT: begin
`ifdef LOCKOUT_TIMER_EN
                if (r_timer == '0) begin
                    w_state_next = S_IDLE;
                    w_wrong_next = 4'd0;
                end
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Indicator values for the coming cycle, derived from the next state
    always_comb begin
        w_open_d   = (w_state_next == S_OPEN);
        w_save_d   = (w_state_next == S_SAVED);
        w_locked_d = (w_state_next == S_LOCKOUT);
        w_change_d = (w_state_next == S_CHG_NEW) || (w_state_next == S_CHG_CONFIRM);
    end

    // State, timer, code storage, entry buffer and registered outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_key_q       <= '0;
            r_key_q2      <= '0;
            r_code        <= DEFAULT_CODE;
            r_pending     <= '0;
            r_cnt         <= '0;
            r_timer       <= '0;
            o_data        <= '0;
            o_wrong_cnt   <= '0;
            o_open        <= 1'b0;
            o_save_light  <= 1'b0;
            o_locked      <= 1'b0;
            o_change_mode <= 1'b0;
        end else begin
            r_key_q       <= i_key;
            r_key_q2      <= r_key_q;
            r_state       <= w_state_next;
            o_wrong_cnt   <= w_wrong_next;
            o_open        <= w_open_d;
            o_save_light  <= w_save_d;
            o_locked      <= w_locked_d;
            o_change_mode <= w_change_d;

            if (w_state_next != r_state) begin
                case (w_state_next)
                    S_OPEN, S_SAVED: r_timer <= TW'(OPEN_CYCLES - 1);
                    S_LOCKOUT:       r_timer <= TW'(LOCKOUT_CYCLES - 1);
                    default:         r_timer <= r_timer;
                endcase
            end else if (r_timer != '0) begin
                r_timer <= r_timer - TW'(1);
            end

            if (r_state == S_CHG_NEW && w_state_next == S_CHG_CONFIRM) r_pending <= o_data;
            if (r_state == S_CHG_CONFIRM && w_state_next == S_SAVED)   r_code    <= r_pending;

            if ((w_state_next != r_state) || w_enter || w_star) begin
                o_data <= '0;
                r_cnt  <= '0;
            end else if (w_digit_ev && w_accepting && !w_full) begin
                o_data <= (o_data << 4) | CW'(w_digit_val);
                r_cnt  <= r_cnt + NW'(1);
            end
        end
    end
endmodule
